result_serializer: RTL



---
 rtl/result_ser_pkg.sv | 23 ++
 rtl/result_fifo.sv | 60 ++++++
 rtl/result_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/result_ser_pkg.sv
// Shared constants and types for the result serializer.
//   IN_W / CHUNK_W / DEPTH : default geometry (36-bit word, 9-bit chunk, 4-deep FIFO)
//   CHUNKS                 : chunks per word
//   CNT_W                  : width of the chunk counter
//   WIDTHS_OK              : word splits evenly into chunks
//   ser_state_t            : serializer FSM states
package result_ser_pkg;

    localparam int IN_W    = 36;
    localparam int CHUNK_W = 9;
    localparam int DEPTH   = 4;

    localparam int CHUNKS  = IN_W / CHUNK_W;
    localparam int CNT_W   = $clog2(CHUNKS);

    localparam bit WIDTHS_OK = (IN_W % CHUNK_W) == 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding whole result words.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : write wdata at the tail (caller guarantees a free slot)
//   pop        : advance the head (caller guarantees non-empty)
//   wdata      : word to write
//   rdata      : current head word (combinational from the array)
//   full/empty : occupancy flags
// The head is read without a register stage so a word written on one
// edge can be popped on the very next edge. Push and pop on the same
// edge while full is legal: the slot being written is the one being
// popped, and the pop sees the old contents.
module result_fifo
    import result_ser_pkg::*;
#(
    parameter int WIDTH = IN_W,
    parameter int DEPTH = result_ser_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr_reg[ADDR_W-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

endmodule

// File: rtl/result_serializer.sv
// Buffers 36-bit results from the core and emits each as four 9-bit
// chunks, MSB first, over a ready/valid handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : result strobe from the core (no backpressure)
//   in         : result word
//   out_ready  : sink accepts the current chunk
//   out_valid  : chunk on out is valid
//   out        : current chunk
//   out_last   : final chunk of a word
//   overflow   : sticky, a result was dropped because all buffering was full
//   word_cnt   : number of fully transmitted words (wraps)
module result_serializer
    import result_ser_pkg::*;
#(
    parameter int IN_W    = result_ser_pkg::IN_W,
    parameter int CHUNK_W = result_ser_pkg::CHUNK_W,
    parameter int DEPTH   = result_ser_pkg::DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [CHUNK_W-1:0] out,
    output logic               out_last,
    output logic               overflow,
    output logic [7:0]         word_cnt
);

    // Geometry must match the package-level chunk counter and a
    // power-of-two FIFO.
    if ((IN_W % CHUNK_W) != 0 || (IN_W / CHUNK_W) != CHUNKS || !WIDTHS_OK ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geometry
        $error("result_serializer: unsupported IN_W/CHUNK_W/DEPTH");
    end

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    ser_state_t       state_reg,     state_next;
    logic [IN_W-1:0]  shift_reg,     shift_next;
    logic [CNT_W-1:0] chunk_cnt_reg, chunk_cnt_next;
    logic [7:0]       word_cnt_reg,  word_cnt_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_last_reg,  out_last_next;
    logic             overflow_reg,  overflow_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic [IN_W-1:0]  fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    result_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop on this edge frees a slot for a simultaneous push.
    assign fifo_push = in_valid && (!fifo_full || fifo_pop);

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        chunk_cnt_next = chunk_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        overflow_next  = overflow_reg;
        fifo_pop       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    shift_next     = fifo_rdata;
                    chunk_cnt_next = '0;
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b0;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (chunk_cnt_reg != LAST_CHUNK) begin
                        shift_next     = shift_reg << CHUNK_W;
                        chunk_cnt_next = chunk_cnt_reg + 1'b1;
                        out_last_next  = (chunk_cnt_next == LAST_CHUNK);
                    end else begin
                        word_cnt_next = word_cnt_reg + 8'd1;
                        if (!fifo_empty) begin
                            // Back-to-back: next word replaces the finished one.
                            fifo_pop       = 1'b1;
                            shift_next     = fifo_rdata;
                            chunk_cnt_next = '0;
                            out_last_next  = 1'b0;
                        end else begin
                            // shift_reg is left alone so out keeps its last chunk.
                            out_valid_next = 1'b0;
                            out_last_next  = 1'b0;
                            state_next     = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (in_valid && fifo_full && !fifo_pop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            chunk_cnt_reg <= '0;
            word_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            chunk_cnt_reg <= chunk_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign out       = shift_reg[IN_W-1 -: CHUNK_W];
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign overflow  = overflow_reg;
    assign word_cnt  = word_cnt_reg;

endmodule
